// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC rotation/vectoring blocks.
// Angle format: 256 LSB per degree (45 deg = 11520).
// Holds the arctangent table, quadrant angles, inverse-gain constant and FSM state type.
package cordic_pkg;

   localparam int ATAN_W       = 16;
   localparam int ANGLE_90     = 23040;
   localparam int ANGLE_180    = 46080;
   localparam int INV_GAIN_Q16 = 39797;   // round(2^16 / K), K ~= 1.6468

   // atan(2^-i) in 256 LSB/degree; index 15 is unused and reads as zero.
   localparam logic [ATAN_W-1:0] ATAN_TABLE [16] = '{
      16'd11520, 16'd6801, 16'd3593, 16'd1824, 16'd916, 16'd458, 16'd229, 16'd115,
      16'd57,    16'd29,   16'd14,   16'd7,    16'd4,   16'd2,   16'd1,   16'd0
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cordic_atan_lut.sv
// Arctangent lookup: idx -> atan(2^-idx) in 256 LSB/degree.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of idx.
// Ports: idx (4-bit iteration index), atan_val (unsigned angle constant).
module cordic_atan_lut
   import cordic_pkg::*;
(
   input  logic [3:0]        idx,
   output logic [ATAN_W-1:0] atan_val
);

   always_comb begin
      atan_val = ATAN_TABLE[idx];
   end

endmodule

// File: rtl/cordic_rotation.sv
// Iterative rotation-mode CORDIC: (mag_in, angle_in) -> (x_out, y_out) = mag*(cos, sin).
// Latency: start sampled at edge E0, valid pulses for one cycle after edge E(ITERATIONS+1).
// Backpressure: none; start is ignored while busy, one result per ITERATIONS+2 cycles.
// Ports: clk, rst (sync, active-high), start, mag_in, angle_in (256 LSB/deg),
//        busy, valid, x_out, y_out.
// Build option: define CORDIC_ROT_GAIN_COMP_EN to pre-scale the magnitude by 1/K
// so outputs are unity gain; otherwise outputs carry the CORDIC gain K ~= 1.6468.
module cordic_rotation
   import cordic_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ITERATIONS = 15
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] mag_in,
   input  logic signed [WIDTH-1:0] angle_in,
   output logic                    busy,
   output logic                    valid,
   output logic signed [WIDTH-1:0] x_out,
   output logic signed [WIDTH-1:0] y_out
);

   // Two guard bits on x/y absorb the CORDIC gain growth.
   localparam int IW = WIDTH + 2;

   localparam logic signed [WIDTH-1:0] A90  = WIDTH'(ANGLE_90);
   localparam logic signed [WIDTH-1:0] A180 = WIDTH'(ANGLE_180);
   localparam logic [3:0]              LAST = 4'(ITERATIONS - 1);

   state_t state, state_nxt;

   logic [3:0]              iter;
   logic signed [IW-1:0]    x_q, y_q;
   logic signed [WIDTH-1:0] z_q;
   logic                    neg_q;

   logic [ATAN_W-1:0]       atan_val;
   logic signed [WIDTH-1:0] atan_w;
   logic signed [IW-1:0]    x_sh, y_sh;
   logic signed [WIDTH-1:0] z_load;
   logic                    neg_load;
   logic signed [IW-1:0]    x_load;

   cordic_atan_lut u_atan_lut (
      .idx      (iter),
      .atan_val (atan_val)
   );

   assign atan_w = signed'(WIDTH'(atan_val));
   assign x_sh   = x_q >>> iter;
   assign y_sh   = y_q >>> iter;
   assign busy   = (state != IDLE);

   // Fold angles beyond +/-90 deg into range by rotating 180 deg; the result
   // is negated at the end. Exactly +/-90 deg is within CORDIC convergence.
   always_comb begin
      z_load   = angle_in;
      neg_load = 1'b0;
      if (angle_in > A90) begin
         z_load   = angle_in - A180;
         neg_load = 1'b1;
      end else if (angle_in < -A90) begin
         z_load   = angle_in + A180;
         neg_load = 1'b1;
      end
   end

`ifdef CORDIC_ROT_GAIN_COMP_EN
   localparam logic signed [2*WIDTH-1:0] INV_GAIN_W = (2*WIDTH)'(INV_GAIN_Q16);
   logic signed [2*WIDTH-1:0] mag_ext;
   logic signed [2*WIDTH-1:0] mag_prod;

   assign mag_ext  = {{WIDTH{mag_in[WIDTH-1]}}, mag_in};
   assign mag_prod = mag_ext * INV_GAIN_W;
   assign x_load   = IW'(mag_prod >>> 16);
`else
   assign x_load   = IW'(mag_in);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ITER;
         ITER:    if (iter == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         iter  <= 4'd0;
         x_q   <= '0;
         y_q   <= '0;
         z_q   <= '0;
         neg_q <= 1'b0;
         valid <= 1'b0;
         x_out <= '0;
         y_out <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  x_q   <= x_load;
                  y_q   <= '0;
                  z_q   <= z_load;
                  neg_q <= neg_load;
                  iter  <= 4'd0;
               end
            end
            ITER: begin
               if (!z_q[WIDTH-1]) begin
                  x_q <= x_q - y_sh;
                  y_q <= y_q + x_sh;
                  z_q <= z_q - atan_w;
               end else begin
                  x_q <= x_q + y_sh;
                  y_q <= y_q - x_sh;
                  z_q <= z_q + atan_w;
               end
               iter <= iter + 4'd1;
            end
            DONE: begin
               x_out <= neg_q ? WIDTH'(-x_q) : WIDTH'(x_q);
               y_out <= neg_q ? WIDTH'(-y_q) : WIDTH'(y_q);
               valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_rotation.sv
// Self-checking bench for cordic_rotation: directed vector table, random vectors
// against a floating-point polar-to-cartesian model, and timing corner sequences.
// Expected scale follows CORDIC_ROT_GAIN_COMP_EN (unity gain) or K when undefined.
module tb_cordic_rotation;

   localparam int WIDTH = 32;
   localparam int ITERS = 15;
   localparam real PI   = 3.14159265358979;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic signed [WIDTH-1:0] mag_in;
   logic signed [WIDTH-1:0] angle_in;
   logic                    busy;
   logic                    valid;
   logic signed [WIDTH-1:0] x_out;
   logic signed [WIDTH-1:0] y_out;

   int n_cmp = 0;
   int n_bad = 0;

   cordic_rotation #(.WIDTH(WIDTH), .ITERATIONS(ITERS)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mag_in   (mag_in),
      .angle_in (angle_in),
      .busy     (busy),
      .valid    (valid),
      .x_out    (x_out),
      .y_out    (y_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int mag;
      int ang;
      int ex;   // ideal mag*cos
      int ey;   // ideal mag*sin
   } vec_t;

   task automatic check(input string name, input longint act, input longint exp, input longint tol);
      n_cmp++;
      if (act > exp + tol || act < exp - tol) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
      end
   endtask

   // Apply one request from IDLE and wait for valid; lat = edges after the accepting edge.
   task automatic run_conv(input int mag, input int ang, output int xo, output int yo, output int lat);
      mag_in   = mag;
      angle_in = ang;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (valid) begin
            lat = c;
            break;
         end
      end
      xo = x_out;
      yo = y_out;
   endtask

   initial begin
      vec_t vecs[10];
      real  k_gain, g, p, ideal_x, ideal_y, rad;
      int   tol_d, xo, yo, lat, cnt, first, second, mag, ang, tol_r;

      vecs[0] = '{10000,      0,  10000,      0};
      vecs[1] = '{10000,   7680,   8660,   5000};
      vecs[2] = '{10000,  23040,      0,  10000};
      vecs[3] = '{10000,  46080, -10000,      0};
      vecs[4] = '{10000, -34560,  -7071,  -7071};
      vecs[5] = '{10000, -23040,      0, -10000};
      vecs[6] = '{10000, -46080, -10000,      0};
      vecs[7] = '{20000,  11520,  14142,  14142};
      vecs[8] = '{    0,  11520,      0,      0};
      vecs[9] = '{10000,  30720,  -5000,   8660};

      k_gain = 1.0;
      p      = 1.0;
      for (int i = 0; i < ITERS; i++) begin
         k_gain = k_gain * $sqrt(1.0 + p);
         p      = p / 4.0;
      end
`ifdef CORDIC_ROT_GAIN_COMP_EN
      g     = k_gain * 39797.0 / 65536.0;
      tol_d = 8;
`else
      g     = k_gain;
      tol_d = 16;
`endif

      // Reset state
      rst      = 1'b1;
      start    = 1'b0;
      mag_in   = '0;
      angle_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",  busy,  0, 0);
      check("reset_valid", valid, 0, 0);
      check("reset_x",     x_out, 0, 0);
      check("reset_y",     y_out, 0, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table
      for (int v = 0; v < 10; v++) begin
         run_conv(vecs[v].mag, vecs[v].ang, xo, yo, lat);
         check($sformatf("vec%0d_latency", v), lat, 16, 0);
         check($sformatf("vec%0d_x", v), xo, longint'($rtoi(g * vecs[v].ex + (vecs[v].ex >= 0 ? 0.5 : -0.5))), tol_d);
         check($sformatf("vec%0d_y", v), yo, longint'($rtoi(g * vecs[v].ey + (vecs[v].ey >= 0 ? 0.5 : -0.5))), tol_d);
         if (v == 0) begin
            @(posedge clk); #1;
            check("valid_pulse_width", valid, 0, 0);
         end
      end

      // Random vectors against floating-point model
      for (int t = 0; t < 40; t++) begin
         mag = int'($urandom_range(0, 65535));
         ang = int'($urandom_range(0, 92160)) - 46080;
         rad = real'(ang) * PI / (180.0 * 256.0);
         ideal_x = g * real'(mag) * $cos(rad);
         ideal_y = g * real'(mag) * $sin(rad);
         tol_r = 16 + mag / 1000;
         run_conv(mag, ang, xo, yo, lat);
         check($sformatf("rand%0d_latency", t), lat, 16, 0);
         check($sformatf("rand%0d_x(m=%0d,a=%0d)", t, mag, ang), xo, longint'($rtoi(ideal_x + (ideal_x >= 0.0 ? 0.5 : -0.5))), tol_r);
         check($sformatf("rand%0d_y(m=%0d,a=%0d)", t, mag, ang), yo, longint'($rtoi(ideal_y + (ideal_y >= 0.0 ? 0.5 : -0.5))), tol_r);
      end

      // Start pulses while busy are ignored
      mag_in   = 10000;
      angle_in = 0;
      start    = 1'b1;
      @(posedge clk); #1;
      cnt   = 0;
      first = -1;
      for (int c = 1; c <= 40; c++) begin
         start = (c == 3 || c == 8);
         @(posedge clk); #1;
         if (valid) begin
            cnt++;
            if (first < 0) first = c;
         end
      end
      start = 1'b0;
      check("busy_start_valid_count", cnt, 1, 0);
      check("busy_start_latency", first, 16, 0);

      // Start held high: back-to-back results every ITERS+2 cycles
      start  = 1'b1;
      cnt    = 0;
      first  = -1;
      second = -1;
      for (int c = 0; c <= 55; c++) begin
         @(posedge clk); #1;
         if (valid) begin
            cnt++;
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
      end
      start = 1'b0;
      check("held_start_count", cnt, 3, 0);
      check("held_start_period", second - first, 17, 0);
      check("held_start_x", x_out, longint'($rtoi(g * 10000.0 + 0.5)), tol_d);
      cnt = 0;
      for (int c = 0; c < 40 && busy; c++) begin
         @(posedge clk); #1;
      end
      check("drain_idle", busy, 0, 0);

      // Reset mid-conversion aborts it
      mag_in   = 10000;
      angle_in = 7680;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_busy",  busy,  0, 0);
      check("midrst_valid", valid, 0, 0);
      check("midrst_x",     x_out, 0, 0);
      check("midrst_y",     y_out, 0, 0);
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (valid) cnt++;
      end
      check("midrst_no_valid", cnt, 0, 0);
      run_conv(10000, 7680, xo, yo, lat);
      check("post_rst_latency", lat, 16, 0);
      check("post_rst_x", xo, longint'($rtoi(g * 8660.254 + 0.5)), tol_d);
      check("post_rst_y", yo, longint'($rtoi(g * 5000.0 + 0.5)), tol_d);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
